// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CLK_PERIOD_NS = 20;

    // Bit counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand request / result response handshake bundle for serial_add_ctrl.
interface serial_add_ctrl_if #(
    parameter int WIDTH = adder_pkg::DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single 1-bit full-adder cell reused every cycle by the serial controller.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH cycles, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    serial_add_ctrl_if.slave bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONE  = WIDTH'(1) << (WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;

    logic fa_s;
    logic fa_cout;

    fullAdder u_cell (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .cout(fa_cout)
    );

    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        sum_sr_d   = sum_sr_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = (sum_sr_q >> 1) | (fa_s ? MSB_ONE : '0);
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // carry_q here is the carry into the MSB, so overflow is
                    // resolved in the same edge that publishes the result.
                    cnt_d      = '0;
                    sum_d      = sum_sr_d;
                    cout_d     = fa_cout;
                    overflow_d = carry_q ^ fa_cout;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            sum_sr_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            sum_sr_q   <= sum_sr_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 1, 8 and 16, checked
// against an arithmetic model of a+b+cin.
module tb_serial_add_ctrl;
    import adder_pkg::*;

    localparam int NW = 3;

    logic clk;
    logic reset;

    logic        iv   [NW];
    logic        ordy [NW];
    logic        cin_v[NW];
    logic [15:0] a_v  [NW];
    logic [15:0] b_v  [NW];
    logic        ir   [NW];
    logic        ov   [NW];
    logic        co   [NW];
    logic        of   [NW];
    logic [15:0] s_v  [NW];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #(CLK_PERIOD_NS / 2) clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 8 : 16);
            serial_add_ctrl_if #(.WIDTH(W)) bus ();
            assign bus.in_valid  = iv[gi];
            assign bus.a         = a_v[gi][W-1:0];
            assign bus.b         = b_v[gi][W-1:0];
            assign bus.cin       = cin_v[gi];
            assign bus.out_ready = ordy[gi];
            assign ir[gi]        = bus.in_ready;
            assign ov[gi]        = bus.out_valid;
            assign co[gi]        = bus.cout;
            assign of[gi]        = bus.overflow;
            assign s_v[gi]       = 16'(bus.sum);
            serial_add_ctrl #(.WIDTH(W)) dut (
                .clk  (clk),
                .reset(reset),
                .bus  (bus)
            );
        end
    endgenerate

    function automatic int w_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 8 : 16);
    endfunction

    // Reference: returns {overflow, cout, sum} from plain integer addition.
    function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
        logic [31:0] m32;
        logic [15:0] mask, am, bm, s;
        logic [16:0] full;
        logic        c, o;
        m32  = (32'd1 << w) - 32'd1;
        mask = m32[15:0];
        am   = a & mask;
        bm   = b & mask;
        full = 17'(am) + 17'(bm) + 17'(cin);
        s    = full[15:0] & mask;
        c    = full[w];
        o    = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        return {o, c, s};
    endfunction

    // One operation: present operands, measure latency, hold result through
    // stalls, then confirm the result is retired exactly once.
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input int stall_n, input bit junk,
                          input logic [17:0] exp);
        int w, t, stalls;
        bit r, fin;
        logic [19:0] got, want;
        w = w_of(idx);
        a_v[idx] = a; b_v[idx] = b; cin_v[idx] = cin;
        iv[idx] = 1'b1; ordy[idx] = 1'b0;
        t = 0;
        while (ir[idx] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (ir[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout w=%0d: in_ready=%b required 1", w, ir[idx]);
            iv[idx] = 1'b0;
            return;
        end
        t = 0;
        @(negedge clk);
        t++;
        iv[idx] = 1'b0;
        a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom); cin_v[idx] = 1'($urandom_range(1));
        while (ov[idx] !== 1'b1 && t < w + 12) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t != w + 1 || ov[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL latency w=%0d: out_valid after %0d cycles required %0d", w, t, w + 1);
            if (ov[idx] !== 1'b1) return;
        end
        stalls = 0;
        fin = 1'b0;
        while (!fin) begin
            got  = {ov[idx], ir[idx], of[idx], co[idx], s_v[idx]};
            want = {1'b1, 1'b0, exp};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL result w=%0d a=%h b=%h cin=%b: {ov,ir,ovf,cout,sum}=%h required %h",
                         w, a, b, cin, got, want);
            end
            if (stall_n < 0) r = ($urandom_range(99) < 70);
            else             r = (stalls >= stall_n);
            if (stalls >= 200) r = 1'b1;
            ordy[idx] = r;
            if (junk) begin
                iv[idx] = 1'($urandom_range(1));
                a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom);
            end
            @(negedge clk);
            if (r) fin = 1'b1;
            else   stalls++;
        end
        iv[idx] = 1'b0;
        ordy[idx] = 1'b0;
        got  = {ov[idx], ir[idx], of[idx], co[idx], s_v[idx]};
        want = {1'b0, 1'b1, exp};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL post_handshake w=%0d: {ov,ir,ovf,cout,sum}=%h required %h", w, got, want);
        end
    endtask

    task automatic test_reset();
        logic [19:0] got;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NW; i++) begin
            got = {ir[i], ov[i], of[i], co[i], s_v[i]};
            n_checks++;
            if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
                n_fail++;
                $display("FAIL reset w=%0d: {ir,ov,ovf,cout,sum}=%h required %h",
                         w_of(i), got, {1'b1, 19'h0});
            end
        end
    endtask

    task automatic test_basic();
        run_op(1, 16'h005A, 16'h003C, 1'b0, 0, 1'b0, {1'b1, 1'b0, 16'h0096});
    endtask

    task automatic test_carry();
        run_op(1, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0, {1'b0, 1'b1, 16'h0000});
        run_op(1, 16'h00FF, 16'h0000, 1'b1, 0, 1'b0, {1'b0, 1'b1, 16'h0000});
    endtask

    task automatic test_backpressure();
        run_op(1, 16'h007F, 16'h0001, 1'b0, 5, 1'b1, {1'b1, 1'b0, 16'h0080});
    endtask

    task automatic test_abort();
        bit seen_ov;
        iv[1] = 1'b1; a_v[1] = 16'h0011; b_v[1] = 16'h0022; cin_v[1] = 1'b0; ordy[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({ir[1], ov[1], s_v[1]} !== {1'b1, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL abort_idle: {ir,ov,sum}=%h required %h", {ir[1], ov[1], s_v[1]},
                     {1'b1, 17'h0});
        end
        seen_ov = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (ov[1] === 1'b1) seen_ov = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen_ov) begin
            n_fail++;
            $display("FAIL abort_no_result: out_valid rose=%b required 0", seen_ov);
        end
        ordy[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n_acc, n_res, last;
        n_acc = 0; n_res = 0; last = 0;
        iv[1] = 1'b1; a_v[1] = 16'h0010; b_v[1] = 16'h0020; cin_v[1] = 1'b1; ordy[1] = 1'b1;
        for (int c = 0; c < 57; c++) begin
            if (c == 42) iv[1] = 1'b0;
            if (ir[1] === 1'b1 && iv[1] === 1'b1) begin
                if (n_acc > 0) begin
                    n_checks++;
                    if (c - last != 10) begin
                        n_fail++;
                        $display("FAIL issue_interval: %0d cycles required 10", c - last);
                    end
                end
                last = c;
                n_acc++;
            end
            if (ov[1] === 1'b1) begin
                n_res++;
                n_checks++;
                if ({of[1], co[1], s_v[1]} !== {1'b0, 1'b0, 16'h0031}) begin
                    n_fail++;
                    $display("FAIL b2b_result: {ovf,cout,sum}=%h required %h",
                             {of[1], co[1], s_v[1]}, {2'b00, 16'h0031});
                end
            end
            @(negedge clk);
        end
        ordy[1] = 1'b0;
        n_checks++;
        if (n_acc != 5 || n_res != n_acc) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d results=%0d required 5 and 5", n_acc, n_res);
        end
    endtask

    task automatic test_random(input int idx, input int nops);
        logic [15:0] a, b;
        logic        cin;
        for (int i = 0; i < nops; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom_range(1));
            run_op(idx, a, b, cin, -1, 1'($urandom_range(1)), model(w_of(idx), a, b, cin));
            repeat ($urandom_range(2)) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NW; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; cin_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
        end
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random(0, 400);
        test_random(1, 400);
        test_random(2, 400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
